// File: rtl/threebitdowncounter_pkg.sv
// ---------------------------------------------------------------------------
// threebitdowncounter_pkg
// Shared definitions for the loadable down-counter:
//   - state_t       : controller states IDLE / RUN / DONE
//   - DEFAULT_WIDTH : default counter width in bits
// ---------------------------------------------------------------------------
package threebitdowncounter_pkg;

    localparam int DEFAULT_WIDTH = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage : threebitdowncounter_pkg

// File: rtl/threebitdowncounter.sv
// ---------------------------------------------------------------------------
// threebitdowncounter
// Loadable down-counter with a small IDLE/RUN/DONE controller.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   asynchronous, active-low reset
//   ld         in   load data_in (wins over dec)
//   dec        in   decrement request
//   data_in    in   [WIDTH-1:0] load value
//   data_out   out  [WIDTH-1:0] registered count
//   busy       out  high while in RUN
//   done       out  high for the single DONE cycle
//   underflow  out  sticky flag for dec at zero (check build only)
//
// Build option:
//   UNDERFLOW_CHECK_EN  defined   : dec at zero holds the count at 0, sets the
//                                   sticky underflow flag and emits a
//                                   simulation-only warning.
//                       undefined : dec at zero wraps to all-ones and enters
//                                   RUN; underflow is tied low.
// ---------------------------------------------------------------------------
module threebitdowncounter
    import threebitdowncounter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ld,
    input  logic             dec,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             busy,
    output logic             done,
    output logic             underflow
);

    localparam logic [WIDTH-1:0] CNT_ZERO = '0;
    localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1);
    localparam logic [WIDTH-1:0] CNT_MAX  = '1;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             uf_event;

    // A dec at zero only exists when no load overrides it. The count is zero
    // exactly in IDLE and DONE, so this covers both of those states.
    assign uf_event = dec && !ld && (cnt_q == CNT_ZERO);

    // -----------------------------------------------------------------------
    // Next-state / next-count logic
    // -----------------------------------------------------------------------
    always_comb begin
        // DONE always falls back to IDLE unless something below overrides it.
        state_d = (state_q == DONE) ? IDLE : state_q;
        cnt_d   = cnt_q;

        if (ld) begin
            cnt_d   = data_in;
            state_d = (data_in != CNT_ZERO) ? RUN : DONE;
        end else if (uf_event) begin
`ifdef UNDERFLOW_CHECK_EN
            // Count stays at 0; only the flag records the event.
            cnt_d = CNT_ZERO;
`else
            // Wrap-around restarts a full countdown, also from DONE.
            cnt_d   = CNT_MAX;
            state_d = RUN;
`endif
        end else if (dec && (state_q == RUN)) begin
            cnt_d = cnt_q - CNT_ONE;
            if (cnt_q == CNT_ONE) begin
                state_d = DONE;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Output decode (registered alongside the state)
    // -----------------------------------------------------------------------
    always_comb begin
        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

    // -----------------------------------------------------------------------
    // State / counter register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= CNT_ZERO;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign data_out = cnt_q;
    assign busy     = busy_q;
    assign done     = done_q;

`ifdef UNDERFLOW_CHECK_EN
    logic underflow_q, underflow_d;

    // Sticky until reset; a later load does not clear it.
    always_comb begin
        underflow_d = underflow_q | uf_event;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            underflow_q <= 1'b0;
        end else begin
            underflow_q <= underflow_d;
        end
    end

    assign underflow = underflow_q;

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (rst && uf_event) begin
            $warning("%m: Counter Underflow");
        end
    end
`endif
`else
    assign underflow = 1'b0;
`endif

endmodule : threebitdowncounter
